// File: rtl/jzjpcc_pkg.sv
// Shared encodings for the jzjpcc execute stage: operand-mux modes,
// ALU operation codes (RV32I funct3 encoding) and rd source selects.
package jzjpcc_pkg;

  // Operand selection applied before the ALU
  localparam logic [1:0] MUX_RS1_RS2  = 2'b00;
  localparam logic [1:0] MUX_RS1_IMM  = 2'b01;
  localparam logic [1:0] MUX_PC_IMM   = 2'b10;  // auipc
  localparam logic [1:0] MUX_ZERO_IMM = 2'b11;  // lui

  // ALU operations, identical to the RV32I OP/OP-IMM funct3 field
  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_SLL     = 3'b001;
  localparam logic [2:0] ALU_SLT     = 3'b010;
  localparam logic [2:0] ALU_SLTU    = 3'b011;
  localparam logic [2:0] ALU_XOR     = 3'b100;
  localparam logic [2:0] ALU_SRL_SRA = 3'b101;
  localparam logic [2:0] ALU_OR      = 3'b110;
  localparam logic [2:0] ALU_AND     = 3'b111;

  // Where the memory stage takes the rd write value from
  localparam logic RD_SRC_ALU = 1'b0;
  localparam logic RD_SRC_MEM = 1'b1;

endpackage

// File: rtl/jzjpcc_execute_if.sv
// Decode -> execute bundle. These are registered decode-stage fields with
// no handshake: the execute stage consumes them every cycle, and flow
// control comes only from the hazard unit's flush/stall on the execute
// module itself. The decode modport drives, the execute modport consumes.
interface jzjpcc_execute_if #(
  parameter int PC_MAX_B = 31
);
  logic              rdWriteEnable;
  logic              memoryWriteEnable;
  logic              rdSource;
  logic [2:0]        aluOperation;
  logic              aluMod;
  logic [1:0]        aluMuxMode;
  logic [4:0]        rdAddr;
  logic [2:0]        funct3;
  logic [31:0]       immediate;
  logic [PC_MAX_B:2] currentPC;
  logic [31:0]       rs1;
  logic [31:0]       rs2;
  logic [4:0]        rs1Addr;
  logic [4:0]        rs2Addr;

  modport decode (
    output rdWriteEnable, memoryWriteEnable, rdSource, aluOperation, aluMod,
           aluMuxMode, rdAddr, funct3, immediate, currentPC, rs1, rs2,
           rs1Addr, rs2Addr
  );

  modport execute (
    input rdWriteEnable, memoryWriteEnable, rdSource, aluOperation, aluMod,
          aluMuxMode, rdAddr, funct3, immediate, currentPC, rs1, rs2,
          rs1Addr, rs2Addr
  );
endinterface

// File: rtl/jzjpcc_execute_alu.sv
// Combinational RV32I ALU. Shift amounts use only b[4:0]; all arithmetic
// wraps modulo 2^32.
module jzjpcc_alu
  import jzjpcc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_operation,
  input  logic        alu_mod,
  output logic [31:0] result
);

  // Operation select; alu_mod picks sub over add and arithmetic over logical right shift
  always_comb begin
    result = '0;
    case (alu_operation)
      ALU_ADD_SUB: result = alu_mod ? (a - b) : (a + b);
      ALU_SLL:     result = a << b[4:0];
      ALU_SLT:     result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU:    result = {31'b0, (a < b)};
      ALU_XOR:     result = a ^ b;
      ALU_SRL_SRA: result = alu_mod ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      ALU_OR:      result = a | b;
      ALU_AND:     result = a & b;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/jzjpcc_execute.sv
// Execute stage: forwards rs1/rs2 from memory and writeback, picks ALU
// operands, and registers the result plus control into the EX/MEM register.
// PC_MAX_B must match the parameter of the connected interface instance.
module jzjpcc_execute
  import jzjpcc_pkg::*;
#(
  parameter int PC_MAX_B = 31
) (
  input  logic                      clock,
  input  logic                      reset,
  jzjpcc_execute_if.execute         executeIF,
  output logic [4:0]                rdAddr_memory,
  output logic                      rdWriteEnable_memory,
  output logic                      memoryWriteEnable_memory,
  output logic                      rdSource_memory,
  output logic [2:0]                funct3_memory,
  output logic [31:0]               aluResult_memory,
  output logic [31:0]               rs2_memory,
  input  logic [4:0]                rdAddr_writeback,
  input  logic                      rdWriteEnable_writeback,
  input  logic [31:0]               rdWriteData_writeback,
  input  logic                      flush_memory,
  input  logic                      stall_memory
);

  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic [31:0] pc_extended;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] alu_result;

  // x0 is never forwarded; a load in the memory stage is never forwarded
  // because its data does not exist yet (the hazard unit stalls instead).
  // The memory stage is younger than writeback, so it wins.
  function automatic logic [31:0] forward(input logic [4:0]  addr,
                                          input logic [31:0] if_value,
                                          input logic        mem_we,
                                          input logic        mem_src,
                                          input logic [4:0]  mem_rd,
                                          input logic [31:0] mem_value,
                                          input logic        wb_we,
                                          input logic [4:0]  wb_rd,
                                          input logic [31:0] wb_value);
    if (addr == 5'd0)                                     return if_value;
    if (mem_we && (mem_src == RD_SRC_ALU) && (mem_rd == addr)) return mem_value;
    if (wb_we && (wb_rd == addr))                         return wb_value;
    return if_value;
  endfunction

  // Forwarded register operands
  always_comb begin
    fwd_rs1 = forward(executeIF.rs1Addr, executeIF.rs1,
                      rdWriteEnable_memory, rdSource_memory, rdAddr_memory,
                      aluResult_memory, rdWriteEnable_writeback,
                      rdAddr_writeback, rdWriteData_writeback);
    fwd_rs2 = forward(executeIF.rs2Addr, executeIF.rs2,
                      rdWriteEnable_memory, rdSource_memory, rdAddr_memory,
                      aluResult_memory, rdWriteEnable_writeback,
                      rdAddr_writeback, rdWriteData_writeback);
  end

  // Word-aligned PC back to a zero-extended byte address
  always_comb begin
    pc_extended = '0;
    pc_extended[PC_MAX_B:2] = executeIF.currentPC;
  end

  // Operand muxes: register/register, register/imm, auipc, lui
  always_comb begin
    operand_a = fwd_rs1;
    operand_b = fwd_rs2;
    case (executeIF.aluMuxMode)
      MUX_RS1_RS2:  begin operand_a = fwd_rs1;     operand_b = fwd_rs2;             end
      MUX_RS1_IMM:  begin operand_a = fwd_rs1;     operand_b = executeIF.immediate; end
      MUX_PC_IMM:   begin operand_a = pc_extended; operand_b = executeIF.immediate; end
      MUX_ZERO_IMM: begin operand_a = '0;          operand_b = executeIF.immediate; end
      default:      begin operand_a = fwd_rs1;     operand_b = fwd_rs2;             end
    endcase
  end

  jzjpcc_alu u_alu (
    .a             (operand_a),
    .b             (operand_b),
    .alu_operation (executeIF.aluOperation),
    .alu_mod       (executeIF.aluMod),
    .result        (alu_result)
  );

  // EX/MEM register: reset > flush (bubble, data still loads) > stall (hold) > load
  always_ff @(posedge clock) begin
    if (reset) begin
      rdAddr_memory            <= '0;
      rdWriteEnable_memory     <= 1'b0;
      memoryWriteEnable_memory <= 1'b0;
      rdSource_memory          <= 1'b0;
      funct3_memory            <= '0;
      aluResult_memory         <= '0;
      rs2_memory               <= '0;
    end else if (flush_memory || !stall_memory) begin
      rdAddr_memory            <= executeIF.rdAddr;
      rdWriteEnable_memory     <= flush_memory ? 1'b0 : executeIF.rdWriteEnable;
      memoryWriteEnable_memory <= flush_memory ? 1'b0 : executeIF.memoryWriteEnable;
      rdSource_memory          <= executeIF.rdSource;
      funct3_memory            <= executeIF.funct3;
      aluResult_memory         <= alu_result;
      rs2_memory               <= fwd_rs2;
    end
  end

endmodule

// File: tb/tb_jzjpcc_execute.sv
// Directed bench for the jzjpcc execute stage: hand-computed results for
// forwarding, operand muxes, ALU operations and EX/MEM register control.
module tb_jzjpcc_execute;

  logic        clock;
  logic        reset;
  logic [4:0]  rdAddr_memory;
  logic        rdWriteEnable_memory;
  logic        memoryWriteEnable_memory;
  logic        rdSource_memory;
  logic [2:0]  funct3_memory;
  logic [31:0] aluResult_memory;
  logic [31:0] rs2_memory;
  logic [4:0]  rdAddr_writeback;
  logic        rdWriteEnable_writeback;
  logic [31:0] rdWriteData_writeback;
  logic        flush_memory;
  logic        stall_memory;

  int total = 0;
  int bad   = 0;

  jzjpcc_execute_if #(.PC_MAX_B(31)) eif ();

  jzjpcc_execute #(.PC_MAX_B(31)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .executeIF                (eif),
    .rdAddr_memory            (rdAddr_memory),
    .rdWriteEnable_memory     (rdWriteEnable_memory),
    .memoryWriteEnable_memory (memoryWriteEnable_memory),
    .rdSource_memory          (rdSource_memory),
    .funct3_memory            (funct3_memory),
    .aluResult_memory         (aluResult_memory),
    .rs2_memory               (rs2_memory),
    .rdAddr_writeback         (rdAddr_writeback),
    .rdWriteEnable_writeback  (rdWriteEnable_writeback),
    .rdWriteData_writeback    (rdWriteData_writeback),
    .flush_memory             (flush_memory),
    .stall_memory             (stall_memory)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idle instruction: everything zero, no writes
  task automatic clear_instr();
    eif.rdWriteEnable     = 1'b0;
    eif.memoryWriteEnable = 1'b0;
    eif.rdSource          = 1'b0;
    eif.aluOperation      = 3'b000;
    eif.aluMod            = 1'b0;
    eif.aluMuxMode        = 2'b00;
    eif.rdAddr            = 5'd0;
    eif.funct3            = 3'b000;
    eif.immediate         = 32'd0;
    eif.currentPC         = 30'd0;
    eif.rs1               = 32'd0;
    eif.rs2               = 32'd0;
    eif.rs1Addr           = 5'd0;
    eif.rs2Addr           = 5'd0;
  endtask

  // Register/register ALU op on non-forwarded sources x20/x21, no writeback
  task automatic alu_rr(input logic [2:0] op, input logic md,
                        input logic [31:0] a, input logic [31:0] b);
    clear_instr();
    eif.aluOperation = op;
    eif.aluMod       = md;
    eif.rs1Addr      = 5'd20;
    eif.rs2Addr      = 5'd21;
    eif.rs1          = a;
    eif.rs2          = b;
    tick();
  endtask

  initial begin
    reset                   = 1'b1;
    flush_memory            = 1'b0;
    stall_memory            = 1'b0;
    rdAddr_writeback        = 5'd0;
    rdWriteEnable_writeback = 1'b0;
    rdWriteData_writeback   = 32'd0;
    clear_instr();
    eif.rdWriteEnable = 1'b1;
    eif.immediate     = 32'hDEAD;
    eif.aluMuxMode    = 2'b11;
    tick();
    tick();

    // Reset state
    chk("reset_rdwe", {31'b0, rdWriteEnable_memory}, 32'd0);
    chk("reset_mwe",  {31'b0, memoryWriteEnable_memory}, 32'd0);
    chk("reset_alu",  aluResult_memory, 32'd0);
    chk("reset_rd",   {27'b0, rdAddr_memory}, 32'd0);
    reset = 1'b0;

    // ADDI x5 = x2(5) + 7
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdAddr = 5'd5; eif.aluMuxMode = 2'b01;
    eif.rs1Addr = 5'd2; eif.rs1 = 32'd5; eif.immediate = 32'd7;
    tick();
    chk("addi_result", aluResult_memory, 32'd12);
    chk("addi_rdwe",   {31'b0, rdWriteEnable_memory}, 32'd1);
    chk("addi_rd",     {27'b0, rdAddr_memory}, 32'd5);

    // add x3 = x10(5) + x11(7)
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdAddr = 5'd3;
    eif.rs1Addr = 5'd10; eif.rs1 = 32'd5; eif.rs2Addr = 5'd11; eif.rs2 = 32'd7;
    tick();
    chk("add_x3", aluResult_memory, 32'd12);

    // sub x4 = x3 - x1(2), stale rs1 = 0: forwarded from memory stage
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdAddr = 5'd4; eif.aluMod = 1'b1;
    eif.rs1Addr = 5'd3; eif.rs1 = 32'd0; eif.rs2Addr = 5'd1; eif.rs2 = 32'd2;
    tick();
    chk("sub_mem_fwd", aluResult_memory, 32'd10);

    // add x3 again, then a bubble
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdAddr = 5'd3;
    eif.rs1Addr = 5'd10; eif.rs1 = 32'd5; eif.rs2Addr = 5'd11; eif.rs2 = 32'd7;
    tick();
    clear_instr();
    tick();
    chk("bubble_rdwe", {31'b0, rdWriteEnable_memory}, 32'd0);

    // sub x4 = x3 - x1 with x3 now only in writeback
    rdAddr_writeback = 5'd3; rdWriteEnable_writeback = 1'b1; rdWriteData_writeback = 32'd12;
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdAddr = 5'd4; eif.aluMod = 1'b1;
    eif.rs1Addr = 5'd3; eif.rs1 = 32'd0; eif.rs2Addr = 5'd1; eif.rs2 = 32'd2;
    tick();
    chk("sub_wb_fwd", aluResult_memory, 32'd10);

    // lui x3 = 1 puts x3=1 in memory stage; writeback holds x3=2
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdAddr = 5'd3; eif.aluMuxMode = 2'b11;
    eif.immediate = 32'd1; eif.rs1Addr = 5'd3; eif.rs1 = 32'h55;
    tick();
    chk("lui_x3", aluResult_memory, 32'd1);
    rdWriteData_writeback = 32'd2;
    clear_instr();
    eif.rs1Addr = 5'd3; eif.rs1 = 32'h55;
    tick();
    chk("fwd_priority", aluResult_memory, 32'd1);

    // Store: rs2 = x3 comes from writeback (memory stage not writing)
    clear_instr();
    eif.memoryWriteEnable = 1'b1; eif.aluMuxMode = 2'b01; eif.funct3 = 3'b010;
    eif.rs1 = 32'h100; eif.immediate = 32'd4; eif.rs2Addr = 5'd3; eif.rs2 = 32'h77;
    tick();
    chk("store_addr", aluResult_memory, 32'h104);
    chk("store_rs2_wb_fwd", rs2_memory, 32'd2);
    chk("store_mwe", {31'b0, memoryWriteEnable_memory}, 32'd1);
    chk("store_rdwe", {31'b0, rdWriteEnable_memory}, 32'd0);
    rdWriteEnable_writeback = 1'b0;

    // x0 is never forwarded, from memory (99) or writeback (5)
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdAddr = 5'd0; eif.aluMuxMode = 2'b11;
    eif.immediate = 32'd99;
    tick();
    rdAddr_writeback = 5'd0; rdWriteEnable_writeback = 1'b1; rdWriteData_writeback = 32'd5;
    clear_instr();
    eif.aluMuxMode = 2'b01;
    tick();
    chk("x0_no_fwd", aluResult_memory, 32'd0);
    rdWriteEnable_writeback = 1'b0;

    // lw x7: loads are not forwarded out of the memory stage
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdSource = 1'b1; eif.rdAddr = 5'd7;
    eif.funct3 = 3'b010; eif.aluMuxMode = 2'b01;
    eif.rs1Addr = 5'd12; eif.rs1 = 32'h200; eif.immediate = 32'd8;
    tick();
    chk("load_addr", aluResult_memory, 32'h208);
    chk("load_src",  {31'b0, rdSource_memory}, 32'd1);
    chk("load_f3",   {29'b0, funct3_memory}, 32'd2);
    clear_instr();
    eif.aluMuxMode = 2'b01; eif.rs1Addr = 5'd7; eif.rs1 = 32'h33;
    tick();
    chk("load_no_fwd", aluResult_memory, 32'h33);

    // ALU operations
    alu_rr(3'b101, 1'b1, 32'h8000_0000, 32'd4);
    chk("sra", aluResult_memory, 32'hF800_0000);
    alu_rr(3'b101, 1'b0, 32'h8000_0000, 32'd4);
    chk("srl", aluResult_memory, 32'h0800_0000);
    alu_rr(3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("slt", aluResult_memory, 32'd1);
    alu_rr(3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("sltu", aluResult_memory, 32'd0);
    alu_rr(3'b001, 1'b0, 32'd1, 32'h25);
    chk("sll_b40", aluResult_memory, 32'h20);
    alu_rr(3'b000, 1'b1, 32'd0, 32'd1);
    chk("sub_wrap", aluResult_memory, 32'hFFFF_FFFF);
    alu_rr(3'b100, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk("xor", aluResult_memory, 32'hFF00_0FF0);
    alu_rr(3'b110, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk("or", aluResult_memory, 32'hFFF0_0FFF);
    alu_rr(3'b111, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    chk("and", aluResult_memory, 32'h00F0_000F);

    // AUIPC and LUI
    clear_instr();
    eif.aluMuxMode = 2'b10; eif.currentPC = 30'h100; eif.immediate = 32'h1000;
    eif.rs1Addr = 5'd22; eif.rs1 = 32'h55;
    tick();
    chk("auipc", aluResult_memory, 32'h1400);
    eif.aluMuxMode = 2'b11;
    tick();
    chk("lui", aluResult_memory, 32'h1000);

    // Flush during a store: enables dropped, data still loads
    clear_instr();
    eif.memoryWriteEnable = 1'b1; eif.rdWriteEnable = 1'b1; eif.aluMuxMode = 2'b01;
    eif.rs1Addr = 5'd22; eif.rs1 = 32'h100; eif.immediate = 32'd4;
    flush_memory = 1'b1;
    tick();
    chk("flush_mwe",  {31'b0, memoryWriteEnable_memory}, 32'd0);
    chk("flush_rdwe", {31'b0, rdWriteEnable_memory}, 32'd0);
    chk("flush_alu",  aluResult_memory, 32'h104);
    flush_memory = 1'b0;

    // Load x9 = 0x30, then stall three cycles with different inputs
    clear_instr();
    eif.rdWriteEnable = 1'b1; eif.rdAddr = 5'd9; eif.aluMuxMode = 2'b01;
    eif.rs1Addr = 5'd22; eif.rs1 = 32'h10; eif.immediate = 32'h20;
    tick();
    chk("pre_stall", aluResult_memory, 32'h30);
    eif.rdAddr = 5'd10; eif.immediate = 32'h99;
    stall_memory = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_alu",  aluResult_memory, 32'h30);
      chk("stall_rd",   {27'b0, rdAddr_memory}, 32'd9);
      chk("stall_rdwe", {31'b0, rdWriteEnable_memory}, 32'd1);
    end

    // Flush beats stall
    flush_memory = 1'b1;
    tick();
    chk("flush_over_stall_rdwe", {31'b0, rdWriteEnable_memory}, 32'd0);
    chk("flush_over_stall_alu",  aluResult_memory, 32'hA9);
    flush_memory = 1'b0;

    // Reload, stall, then reset mid-stall
    tick();
    chk("reload_under_stall", aluResult_memory, 32'hA9);
    stall_memory = 1'b0;
    tick();
    chk("reload", {27'b0, rdAddr_memory}, 32'd10);
    stall_memory = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_stall_rdwe", {31'b0, rdWriteEnable_memory}, 32'd0);
    chk("rst_stall_alu",  aluResult_memory, 32'd0);
    chk("rst_stall_rd",   {27'b0, rdAddr_memory}, 32'd0);
    chk("rst_stall_rs2",  rs2_memory, 32'd0);
    reset = 1'b0;
    stall_memory = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
